// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX-stage operand forwarding select and load-use stall control
// Position 0 is the EX slot; positions 1..DEPTH are the tag stages that follow it.
module hazard_forward_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  parameter int SELW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic [SELW-1:0]   fwd_a,
  output logic [SELW-1:0]   fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              pv  [0:DEPTH];
  logic              prw [0:DEPTH];
  logic [REG_AW-1:0] prd [0:DEPTH];
  // The last stage's load flag is never consulted, so it is not stored.
  logic              pld [0:DEPTH-1];

  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic              ex_use1;
  logic              ex_use2;

  logic              haz1;
  logic              haz2;

  // Scan oldest to youngest so the youngest matching producer is the one kept.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (pv[k] && prw[k] && (prd[k] != '0)) begin
        if (ex_use1 && (prd[k] == ex_rs1)) fwd_a = SELW'(k);
        if (ex_use2 && (prd[k] == ex_rs2)) fwd_b = SELW'(k);
      end
    end
    if (!pv[0]) begin
      fwd_a = '0;
      fwd_b = '0;
    end
  end

  // A nearer non-load producer overrides the hazard flag of an older load.
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (pv[j] && prw[j] && (prd[j] != '0)) begin
        if (prd[j] == id_rs1) haz1 = pld[j] && ((j + 1) < LOAD_STAGE);
        if (prd[j] == id_rs2) haz2 = pld[j] && ((j + 1) < LOAD_STAGE);
      end
    end
  end

  assign stall = id_valid && !flush && ((id_use_rs1 && haz1) || (id_use_rs2 && haz2));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= DEPTH; k++) pv[k] <= 1'b0;
      stall_cnt <= '0;
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        pv[k]  <= pv[k-1];
        prw[k] <= prw[k-1];
        prd[k] <= prd[k-1];
      end
      for (int k = 1; k < DEPTH; k++) pld[k] <= pld[k-1];
      pv[0]   <= id_valid && !flush && !stall;
      prw[0]  <= id_regwrite;
      prd[0]  <= id_rd;
      pld[0]  <= id_memread;
      ex_rs1  <= id_rs1;
      ex_rs2  <= id_rs2;
      ex_use1 <= id_use_rs1;
      ex_use2 <= id_use_rs2;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed bench for hazard_forward_ctrl
// u0 uses default parameters; u1 uses DEPTH=3, LOAD_STAGE=3, CNT_W=2.
module tb_hazard_forward_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        st0, st1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_forward_ctrl u0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_a(fa0), .fwd_b(fb0), .stall(st0), .stall_cnt(cnt0)
  );

  hazard_forward_ctrl #(.DEPTH(3), .LOAD_STAGE(3), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_a(fa1), .fwd_b(fb1), .stall(st1), .stall_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = ld;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
    set_id(1'b1, rs1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1);
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nop();
    flush = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    nop();
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("reset_fwd_a", fa0, 0);
    chk("reset_fwd_b", fb0, 0);
    chk("reset_stall", st0, 0);
    chk("reset_cnt", cnt0, 0);

    // add x5 ; sub x6,x5,x7
    tick(); alu(5, 1, 2); settle();
    tick(); alu(6, 5, 7); settle();
    chk("t1_stall_id", st0, 0);
    tick(); nop(); settle();
    chk("t1_fwd_a", fa0, 1);
    chk("t1_fwd_b", fb0, 0);
    chk("t1_stall", st0, 0);

    // add x5 ; nop ; or x8,x1,x5
    do_reset();
    alu(5, 1, 2); tick();
    nop(); tick();
    alu(8, 1, 5); tick();
    nop(); settle();
    chk("t2_fwd_a", fa0, 0);
    chk("t2_fwd_b_old", fb0, 2);

    // add x5 ; add x5 ; or x8,x1,x5
    do_reset();
    alu(5, 1, 2); tick();
    alu(5, 3, 4); tick();
    alu(8, 1, 5); tick();
    nop(); settle();
    chk("t2_fwd_b_young", fb0, 1);

    // lw x5 ; add x6,x5,x5
    do_reset();
    lw(5, 1); settle();
    chk("t3_lw_no_stall", st0, 0);
    tick(); alu(6, 5, 5); settle();
    chk("t3_stall", st0, 1);
    chk("t3_lw_fwd_a", fa0, 0);
    tick(); settle();
    chk("t3_stall_released", st0, 0);
    chk("t3_bubble_fwd_a", fa0, 0);
    chk("t3_bubble_fwd_b", fb0, 0);
    chk("t3_cnt", cnt0, 1);
    tick(); nop(); settle();
    chk("t3_fwd_a", fa0, 2);
    chk("t3_fwd_b", fb0, 2);
    chk("t3_cnt_hold", cnt0, 1);

    // u1: two stall cycles per load-use pair, counter saturates at 3
    do_reset();
    for (int p = 0; p < 3; p++) begin
      lw(5, 1); tick();
      alu(6, 5, 5); settle();
      chk("t3d_stall_j0", st1, 1);
      tick(); settle();
      chk("t3d_stall_j1", st1, 1);
      tick(); settle();
      chk("t3d_stall_done", st1, 0);
      tick(); nop(); settle();
      chk("t3d_fwd_a", fa1, 3);
      chk("t3d_fwd_b", fb1, 3);
      chk("t3d_cnt", cnt1, (p == 0) ? 2 : 3);
    end

    // u1: nearer non-load producer masks the older load
    do_reset();
    lw(5, 1); tick();
    alu(5, 1, 2); tick();
    alu(6, 5, 5); settle();
    chk("mask_stall", st1, 0);
    tick(); nop(); settle();
    chk("mask_fwd_a", fa1, 1);

    // x0 is never a producer
    do_reset();
    alu(0, 1, 2); tick();
    alu(3, 0, 0); tick();
    nop(); settle();
    chk("t4_fwd_a", fa0, 0);
    chk("t4_fwd_b", fb0, 0);
    lw(0, 1); tick();
    alu(6, 0, 0); settle();
    chk("t4_lw_x0_stall", st0, 0);

    // flush in the stall cycle
    do_reset();
    lw(5, 1); tick();
    alu(6, 5, 1); flush = 1'b1; settle();
    chk("t5_flush_stall", st0, 0);
    tick(); flush = 1'b0; alu(9, 5, 1); settle();
    chk("t5_bubble_fwd_a", fa0, 0);
    chk("t5_next_stall", st0, 0);
    chk("t5_cnt", cnt0, 0);
    tick(); nop(); settle();
    chk("t5_next_fwd_a", fa0, 2);

    // reset during a stall
    do_reset();
    lw(5, 1); tick();
    alu(6, 5, 5); tick();
    tick();
    lw(7, 1); tick();
    alu(8, 7, 7); settle();
    chk("t6_pre_stall", st0, 1);
    chk("t6_pre_cnt", cnt0, 1);
    reset = 1'b1;
    tick(); reset = 1'b0; settle();
    chk("t6_stall", st0, 0);
    chk("t6_fwd_a", fa0, 0);
    chk("t6_fwd_b", fb0, 0);
    chk("t6_cnt", cnt0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
